// File: rtl/operand_join_pkg.sv
// Shared sizing helpers for the operand join block and its side FIFOs.
package operand_join_pkg;

  // Pointer/level width for a FIFO of the given depth: index bits plus a wrap bit.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Depth the join is normally built with; sizes the shared pointer type.
  localparam int JOIN_DEPTH = 2;

  // Read/write pointer (and occupancy) type for a JOIN_DEPTH-entry FIFO.
  typedef logic [level_w(JOIN_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/op_fifo.sv
// Single-clock circular FIFO for one operand side. Pointers carry a wrap bit
// so full and empty are distinguishable without a separate counter.
module op_fifo
  import operand_join_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [N-1:0]              din,
  input  logic                      pop,
  output logic [N-1:0]              head,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int PW = level_w(DEPTH);
  localparam int IW = PW - 1;

  logic [PW-1:0]           wptr, rptr;
  logic [DEPTH-1:0][N-1:0] mem;
  logic                    do_push, do_pop;

  // A full FIFO refuses a push even when it pops in the same cycle, which
  // keeps ready a pure function of registered state.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wptr == rptr);
  assign full  = (wptr[IW-1:0] == rptr[IW-1:0]) && (wptr[IW] != rptr[IW]);
  assign level = wptr - rptr;
  assign head  = mem[rptr[IW-1:0]];

  // Pointer and storage update; reset clears storage so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      mem  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[IW-1:0]] <= din;
        wptr              <= wptr + PW'(1);
      end
      if (do_pop) rptr <= rptr + PW'(1);
    end
  end

endmodule

// File: rtl/operand_join.sv
// Joins two independently handshaked operand streams into matched pairs for
// the downstream AND stage. Each side is buffered in its own FIFO; a pair is
// offered only when both heads are populated, and both heads leave together.
module operand_join
  import operand_join_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = JOIN_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              a_in,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [N-1:0]              b_in,
  input  logic                      b_valid,
  output logic                      b_ready,
  output logic [N-1:0]              a,
  output logic [N-1:0]              b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [level_w(DEPTH)-1:0] a_level,
  output logic [level_w(DEPTH)-1:0] b_level
);

  logic a_full, a_empty, b_full, b_empty;
  logic pop;

  // Readies come straight from FIFO state; no path from out_ready.
  assign a_ready   = !a_full;
  assign b_ready   = !b_full;
  assign out_valid = !a_empty && !b_empty;
  // Shared pop keeps the k-th a operand aligned with the k-th b operand.
  assign pop       = out_valid && out_ready;

  op_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (a_valid && a_ready),
    .din   (a_in),
    .pop   (pop),
    .head  (a),
    .full  (a_full),
    .empty (a_empty),
    .level (a_level)
  );

  op_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (b_valid && b_ready),
    .din   (b_in),
    .pop   (pop),
    .head  (b),
    .full  (b_full),
    .empty (b_empty),
    .level (b_level)
  );

endmodule
